// File: rtl/pipelined_ctrl_pkg.sv
// rtl/pipelined_ctrl_pkg.sv - shared opcodes, control encodings and ctrl_t bundle
// Purpose: opcode constants, ALUOp / ALU-A select encodings and the packed
//          control bundle carried through the ID/EX pipeline register.
// Ports:   none (package).
package pipelined_ctrl_pkg;

  localparam int ALU_OP_W = 2;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] J      = 7'b1101111;
  localparam logic [6:0] JR     = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALUOP_BR    = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [ALU_OP_W-1:0] ALUOP_JUMP  = 2'b11;

  localparam logic [1:0] ASEL_RS1  = 2'b00;
  localparam logic [1:0] ASEL_PC   = 2'b01;
  localparam logic [1:0] ASEL_ZERO = 2'b10;

  typedef struct packed {
    logic                valid;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          a_sel;
    logic                branch;
    logic                jump;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                mem_to_reg;
    logic                illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control-bundle decoder
// Purpose: maps the ID-stage opcode to a ctrl_t bundle and reports which
//          source registers the instruction reads.
// Ports:   valid    - ID holds a real instruction (all outputs 0 when low)
//          opcode   - instr[6:0]
//          ctrl     - decoded control bundle
//          uses_rs1 - instruction reads rs1
//          uses_rs2 - instruction reads rs2
module ctrl_decode
  import pipelined_ctrl_pkg::*;
(
  input  logic       valid,
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       uses_rs1,
  output logic       uses_rs2
);

  always_comb begin
    ctrl     = CTRL_BUBBLE;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    if (valid) begin
      ctrl.valid = 1'b1;
      case (opcode)
        R_TYPE: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_FUNCT;
          uses_rs1       = 1'b1;
          uses_rs2       = 1'b1;
        end
        I_TYPE: begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_FUNCT;
          uses_rs1       = 1'b1;
        end
        LW: begin
          ctrl.alu_src    = 1'b1;
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.alu_op     = ALUOP_ADD;
          uses_rs1        = 1'b1;
        end
        SW: begin
          ctrl.alu_src   = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
          uses_rs1       = 1'b1;
          uses_rs2       = 1'b1;
        end
        BR: begin
          ctrl.branch = 1'b1;
          ctrl.alu_op = ALUOP_BR;
          uses_rs1    = 1'b1;
          uses_rs2    = 1'b1;
        end
        J: begin
          ctrl.jump      = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_JUMP;
          ctrl.a_sel     = ASEL_PC;
        end
        JR: begin
          ctrl.jump      = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_JUMP;
          uses_rs1       = 1'b1;
        end
        LUI: begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.a_sel     = ASEL_ZERO;
        end
        AUIPC: begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.a_sel     = ASEL_PC;
        end
        default: begin
          // Unknown opcode enters the pipe as a flagged bubble.
          ctrl.valid   = 1'b0;
          ctrl.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_controller.sv
// rtl/pipelined_controller.sv - pipelined main decoder with load-use stall and redirect squash
// Purpose: decodes the ID instruction, carries control through ID/EX, EX/MEM
//          and MEM/WB, stalls IF/ID on load-use hazards for LOAD_LATENCY
//          cycles and squashes the ID instruction on an EX redirect.
// Ports:   clk, rst_n (async active-low)
//          id_valid, id_opcode, id_rs1, id_rs2, id_rd - ID-stage instruction
//          ex_redirect    - taken branch / jump resolved in EX
//          pc_write_en, if_id_write_en, if_id_flush - front-end control
//          ex_*           - ID/EX register contents
//          mem_*          - EX/MEM register contents
//          wb_*           - MEM/WB register contents
module pipelined_controller
  import pipelined_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int ALUOP_W      = 2,
  parameter int LOAD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_redirect,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_illegal,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [1:0]            ex_alu_a_sel,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  localparam int CNT_W = $clog2(LOAD_LATENCY) + 1;
  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_LATENCY - 1);

  ctrl_t                 id_ctrl;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;

  ctrl_t                 id_ex_q;
  logic [REG_ADDR_W-1:0] id_ex_rd_q;

  logic                  ex_mem_read_q;
  logic                  ex_mem_write_q;
  logic                  ex_mem_reg_write_q;
  logic                  ex_mem_to_reg_q;
  logic [REG_ADDR_W-1:0] ex_mem_rd_q;

  logic                  mem_wb_reg_write_q;
  logic                  mem_wb_to_reg_q;
  logic [REG_ADDR_W-1:0] mem_wb_rd_q;

  logic [CNT_W-1:0]      stall_cnt_q;
  logic [CNT_W-1:0]      stall_cnt_d;
  logic                  haz;
  logic                  stall;
  logic                  id_ex_load;

  ctrl_decode u_decode (
    .valid    (id_valid),
    .opcode   (id_opcode),
    .ctrl     (id_ctrl),
    .uses_rs1 (id_uses_rs1),
    .uses_rs2 (id_uses_rs2)
  );

  // x0 is excluded since reads of it never depend on a load result.
  always_comb begin
    haz = id_valid && id_ex_q.valid && id_ex_q.mem_read && (id_ex_rd_q != '0) &&
          (((id_ex_rd_q == id_rs1) && id_uses_rs1) ||
           ((id_ex_rd_q == id_rs2) && id_uses_rs2));
  end

  // Stall counter: the hazard cycle itself is the first stall cycle, the
  // counter covers the remaining LOAD_LATENCY-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ex_redirect) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != '0) begin
      stall_cnt_d = stall_cnt_q - 1'b1;
    end else if (haz) begin
      stall_cnt_d = STALL_RELOAD;
    end
  end

  always_comb begin
    stall          = (haz && (stall_cnt_q == '0)) || (stall_cnt_q != '0);
    // A redirect discards the stalled instruction, so it overrides the stall.
    pc_write_en    = ex_redirect || !stall;
    if_id_write_en = ex_redirect || !stall;
    if_id_flush    = ex_redirect;
    id_ex_load     = !ex_redirect && !stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q    <= CTRL_BUBBLE;
      id_ex_rd_q <= '0;
    end else if (id_ex_load) begin
      id_ex_q    <= id_ctrl;
      id_ex_rd_q <= id_ctrl.valid ? id_rd : '0;
    end else begin
      id_ex_q    <= CTRL_BUBBLE;
      id_ex_rd_q <= '0;
    end
  end

  // EX/MEM and MEM/WB always advance; the EX instruction survives a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_read_q      <= 1'b0;
      ex_mem_write_q     <= 1'b0;
      ex_mem_reg_write_q <= 1'b0;
      ex_mem_to_reg_q    <= 1'b0;
      ex_mem_rd_q        <= '0;
      mem_wb_reg_write_q <= 1'b0;
      mem_wb_to_reg_q    <= 1'b0;
      mem_wb_rd_q        <= '0;
    end else begin
      ex_mem_read_q      <= id_ex_q.valid && id_ex_q.mem_read;
      ex_mem_write_q     <= id_ex_q.valid && id_ex_q.mem_write;
      ex_mem_reg_write_q <= id_ex_q.valid && id_ex_q.reg_write;
      ex_mem_to_reg_q    <= id_ex_q.valid && id_ex_q.mem_to_reg;
      ex_mem_rd_q        <= id_ex_q.valid ? id_ex_rd_q : '0;
      mem_wb_reg_write_q <= ex_mem_reg_write_q;
      mem_wb_to_reg_q    <= ex_mem_to_reg_q;
      mem_wb_rd_q        <= ex_mem_rd_q;
    end
  end

  assign ex_valid      = id_ex_q.valid;
  assign ex_alu_src    = id_ex_q.alu_src;
  assign ex_branch     = id_ex_q.branch;
  assign ex_jump       = id_ex_q.jump;
  assign ex_illegal    = id_ex_q.illegal;
  assign ex_alu_op     = ALUOP_W'(id_ex_q.alu_op);
  assign ex_alu_a_sel  = id_ex_q.a_sel;
  assign ex_rd         = id_ex_rd_q;
  assign mem_read      = ex_mem_read_q;
  assign mem_write     = ex_mem_write_q;
  assign mem_rd        = ex_mem_rd_q;
  assign wb_reg_write  = mem_wb_reg_write_q;
  assign wb_mem_to_reg = mem_wb_to_reg_q;
  assign wb_rd         = mem_wb_rd_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// tb/tb_pipelined_controller.sv - self-checking bench for pipelined_controller
module tb_pipelined_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [6:0] id_opcode = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       ex_redirect = 1'b0;

  logic       pc_we [2], ifw [2], flush [2], ex_v [2], ex_src [2], ex_br [2], ex_jmp [2], ex_ill [2];
  logic [1:0] ex_aop [2], ex_asel [2];
  logic [4:0] ex_rd_o [2], mem_rd_o [2], wb_rd_o [2];
  logic       mem_rd_en [2], mem_wr_en [2], wb_rw [2], wb_m2r [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0 uses a single-cycle data memory, instance 1 a 3-cycle one.
  pipelined_controller #(.REG_ADDR_W(5), .ALUOP_W(2), .LOAD_LATENCY(1)) u_ll1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .pc_write_en(pc_we[0]), .if_id_write_en(ifw[0]), .if_id_flush(flush[0]),
    .ex_valid(ex_v[0]), .ex_alu_src(ex_src[0]), .ex_branch(ex_br[0]), .ex_jump(ex_jmp[0]),
    .ex_illegal(ex_ill[0]), .ex_alu_op(ex_aop[0]), .ex_alu_a_sel(ex_asel[0]), .ex_rd(ex_rd_o[0]),
    .mem_read(mem_rd_en[0]), .mem_write(mem_wr_en[0]), .mem_rd(mem_rd_o[0]),
    .wb_reg_write(wb_rw[0]), .wb_mem_to_reg(wb_m2r[0]), .wb_rd(wb_rd_o[0]));

  pipelined_controller #(.REG_ADDR_W(5), .ALUOP_W(2), .LOAD_LATENCY(3)) u_ll3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .pc_write_en(pc_we[1]), .if_id_write_en(ifw[1]), .if_id_flush(flush[1]),
    .ex_valid(ex_v[1]), .ex_alu_src(ex_src[1]), .ex_branch(ex_br[1]), .ex_jump(ex_jmp[1]),
    .ex_illegal(ex_ill[1]), .ex_alu_op(ex_aop[1]), .ex_alu_a_sel(ex_asel[1]), .ex_rd(ex_rd_o[1]),
    .mem_read(mem_rd_en[1]), .mem_write(mem_wr_en[1]), .mem_rd(mem_rd_o[1]),
    .wb_reg_write(wb_rw[1]), .wb_mem_to_reg(wb_m2r[1]), .wb_rd(wb_rd_o[1]));

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  // Properties of an opcode as listed in the instruction table.
  typedef struct packed {
    logic legal, src; logic [1:0] aop, asel;
    logic br, jmp, mr, mw, rw, m2r, u1, u2;
  } props_t;

  function automatic props_t props(input logic [6:0] op);
    case (op)
      OP_R:     return 14'b1_0_10_00_0_0_0_0_1_0_1_1;
      OP_I:     return 14'b1_1_10_00_0_0_0_0_1_0_1_0;
      OP_LW:    return 14'b1_1_00_00_0_0_1_0_1_1_1_0;
      OP_SW:    return 14'b1_1_00_00_0_0_0_1_0_0_1_1;
      OP_BR:    return 14'b1_0_01_00_1_0_0_0_0_0_1_1;
      OP_JAL:   return 14'b1_0_11_01_0_1_0_0_1_0_0_0;
      OP_JALR:  return 14'b1_1_11_00_0_1_0_0_1_0_1_0;
      OP_LUI:   return 14'b1_1_00_10_0_0_0_0_1_0_0_0;
      OP_AUIPC: return 14'b1_1_00_01_0_0_0_0_1_0_0_0;
      default:  return '0;
    endcase
  endfunction

  // Bit layout: [30]pc_we [29]if_id_we [28]flush [27:14]ex bundle [13:7]mem [6:0]wb
  function automatic logic [30:0] got_vec(input int k);
    return {pc_we[k], ifw[k], flush[k], ex_v[k], ex_src[k], ex_br[k], ex_jmp[k], ex_ill[k],
            ex_aop[k], ex_asel[k], ex_rd_o[k], mem_rd_en[k], mem_wr_en[k], mem_rd_o[k],
            wb_rw[k], wb_m2r[k], wb_rd_o[k]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [6:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] d, input logic rdr);
    id_valid = iv; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = d; ex_redirect = rdr;
  endtask

  task automatic do_reset();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: each stage holds the instruction occupying it; stalls
  // are tracked as an absolute cycle until which the front end is frozen.
  typedef struct packed { logic v; logic ill; logic [6:0] op; logic [4:0] rd; } slot_t;
  slot_t m_ex [2], m_mem [2], m_wb [2];
  int    stall_until [2];
  int    lat [2] = '{1, 3};
  int    cyc;

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; stall_until[k] = 0;
    end
    cyc = 0;
  endtask

  task automatic model_step(input int k, output logic [30:0] e);
    props_t pi, pe, pm, pw;
    logic   haz, stl, v, mv, wv, adv;
    pi  = props(id_opcode);
    pe  = props(m_ex[k].op);
    pm  = props(m_mem[k].op);
    pw  = props(m_wb[k].op);
    v   = m_ex[k].v; mv = m_mem[k].v; wv = m_wb[k].v;
    haz = id_valid && v && pe.mr && (m_ex[k].rd != 0) &&
          ((pi.u1 && m_ex[k].rd == id_rs1) || (pi.u2 && m_ex[k].rd == id_rs2));
    stl = (cyc < stall_until[k]) || haz;
    if (haz && cyc >= stall_until[k]) stall_until[k] = cyc + lat[k];
    if (ex_redirect) stall_until[k] = 0;
    adv = ex_redirect || !stl;
    e = {adv, adv, ex_redirect, v, v & pe.src, v & pe.br, v & pe.jmp, m_ex[k].ill,
         v ? pe.aop : 2'b00, v ? pe.asel : 2'b00, v ? m_ex[k].rd : 5'd0,
         mv & pm.mr, mv & pm.mw, mv ? m_mem[k].rd : 5'd0,
         wv & pw.rw, wv & pw.m2r, wv ? m_wb[k].rd : 5'd0};
    m_wb[k]  = m_mem[k];
    m_mem[k] = v ? m_ex[k] : '0;
    if (ex_redirect || stl || !id_valid) m_ex[k] = '0;
    else m_ex[k] = {pi.legal, !pi.legal, id_opcode, pi.legal ? id_rd : 5'd0};
  endtask

  typedef struct {
    string      name;
    logic       iv;
    logic [6:0] op;
    logic [13:0] exp;  // {valid, alu_src, branch, jump, illegal, alu_op, a_sel, rd}
  } vec_t;

  vec_t vecs [11];

  logic [30:0] gv, ev;
  int          n0, n1;
  logic [4:0]  exv0, exv1;
  logic [6:0]  legal_ops [9];

  initial begin
    vecs[0]  = '{"dec_r",     1'b1, OP_R,     14'b1_0_0_0_0_10_00_00111};
    vecs[1]  = '{"dec_i",     1'b1, OP_I,     14'b1_1_0_0_0_10_00_00111};
    vecs[2]  = '{"dec_lw",    1'b1, OP_LW,    14'b1_1_0_0_0_00_00_00111};
    vecs[3]  = '{"dec_sw",    1'b1, OP_SW,    14'b1_1_0_0_0_00_00_00111};
    vecs[4]  = '{"dec_br",    1'b1, OP_BR,    14'b1_0_1_0_0_01_00_00111};
    vecs[5]  = '{"dec_jal",   1'b1, OP_JAL,   14'b1_0_0_1_0_11_01_00111};
    vecs[6]  = '{"dec_jalr",  1'b1, OP_JALR,  14'b1_1_0_1_0_11_00_00111};
    vecs[7]  = '{"dec_lui",   1'b1, OP_LUI,   14'b1_1_0_0_0_00_10_00111};
    vecs[8]  = '{"dec_auipc", 1'b1, OP_AUIPC, 14'b1_1_0_0_0_00_01_00111};
    vecs[9]  = '{"dec_illeg", 1'b1, 7'b0000000, 14'b0_0_0_0_1_00_00_00000};
    vecs[10] = '{"dec_novld", 1'b0, OP_R,     14'b0_0_0_0_0_00_00_00000};
    legal_ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    do_reset();
    for (int k = 0; k < 2; k++) chk($sformatf("reset_state_%0d", k), got_vec(k), 31'h6000_0000);

    // Decode table: one instruction per cycle, no register overlap.
    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].op, 5'd0, 5'd0, 5'd7, 1'b0);
      tick();
      for (int k = 0; k < 2; k++) begin
        gv = got_vec(k);
        chk($sformatf("%s_%0d", vecs[i].name, k), gv[27:14], vecs[i].exp);
      end
    end

    // Illegal opcode must not produce any downstream write.
    do_reset();
    drive(1'b1, 7'b0000000, 5'd1, 5'd2, 5'd9, 1'b0);
    tick();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("illegal_mem", {mem_rd_en[0], mem_wr_en[0], mem_rd_o[0]}, 7'd0);
    tick();
    chk("illegal_wb", {wb_rw[0], wb_m2r[0], wb_rd_o[0]}, 7'd0);

    // Bundle timing: ADD x3, LW x5, SW back to back.
    do_reset();
    drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    chk("add_aluop_t1", ex_aop[0], 2'b10);
    drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    drive(1'b1, OP_SW, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    chk("lw_memread_t2", {mem_rd_en[0], mem_rd_o[0]}, {1'b1, 5'd5});
    chk("add_wb_t3", {wb_rw[0], wb_rd_o[0]}, {1'b1, 5'd3});
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("sw_memwrite", mem_wr_en[0], 1'b1);
    chk("lw_wb", {wb_rw[0], wb_m2r[0], wb_rd_o[0]}, {2'b11, 5'd5});

    // Load-use: LW x5 then ADD rs1=x5 held in ID for four cycles.
    do_reset();
    drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    n0 = 0; n1 = 0; exv0 = '0; exv1 = '0;
    drive(1'b1, OP_R, 5'd5, 5'd2, 5'd6, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      #1;
      n0 += (pc_we[0] == 1'b0) ? 1 : 0;
      n1 += (pc_we[1] == 1'b0) ? 1 : 0;
      tick();
      exv0[c] = ex_v[0];
      exv1[c] = ex_v[1];
    end
    chk("ll1_stall_cycles", n0, 1);
    chk("ll3_stall_cycles", n1, 3);
    chk("ll1_add_reaches_ex", exv0[2:1], 2'b10);
    chk("ll3_add_reaches_ex", exv1[4:1], 4'b1000);

    // x0 is never a hazard source.
    do_reset();
    drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, OP_R, 5'd0, 5'd0, 5'd6, 1'b0);
    #1;
    chk("x0_no_stall", {pc_we[0], pc_we[1]}, 2'b11);
    tick();

    // Redirect wins over a simultaneous load-use hazard.
    do_reset();
    drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    drive(1'b1, OP_R, 5'd5, 5'd2, 5'd6, 1'b1);
    #1;
    chk("redir_front_ll3", {flush[1], pc_we[1], ifw[1]}, 3'b111);
    chk("redir_front_ll1", {flush[0], pc_we[0], ifw[0]}, 3'b111);
    tick();
    chk("redir_squash", {ex_v[1], mem_rd_en[1], mem_rd_o[1]}, {2'b01, 5'd5});
    ex_redirect = 1'b0;
    n1 = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n1 += (pc_we[1] == 1'b0) ? 1 : 0;
      tick();
    end
    chk("redir_no_more_stall", n1, 0);

    // Asynchronous reset in the middle of a load-use stall.
    do_reset();
    drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    drive(1'b1, OP_R, 5'd5, 5'd2, 5'd6, 1'b0);
    #2;
    chk("pre_reset_stall", pc_we[1], 1'b0);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("async_reset_%0d", k), got_vec(k), 31'h6000_0000);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_reset_pcwe", {pc_we[0], pc_we[1]}, 2'b11);
    tick();
    chk("post_reset_no_stall", {pc_we[0], pc_we[1], ex_v[0], ex_v[1]}, 4'b1111);

    // Randomised traffic against the reference model.
    do_reset();
    model_clear();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 85) ? legal_ops[$urandom_range(0, 8)] : 7'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
        model_step(k, ev);
        chk($sformatf("rand_c%0d_u%0d", c, k), got_vec(k), ev);
      end
      cyc++;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
